// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: decodes the instr[31:7] immediate at push time
// and queues {fmt_err, value} in a 2-entry valid/ready buffer with flush.
module imm_ext_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int ERRW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     inm,
  input  logic [2:0]      src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] inmExt,
  output logic            fmt_err,
  output logic [ERRW-1:0] err_cnt
);

  if (DEPTH != 2) begin : g_depth_chk
    $error("imm_ext_pipe: DEPTH must be 2");
  end
  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_ext_pipe: XLEN must be 32 or 64");
  end

  localparam logic [2:0] SRC_I     = 3'b000;
  localparam logic [2:0] SRC_S     = 3'b001;
  localparam logic [2:0] SRC_B     = 3'b010;
  localparam logic [2:0] SRC_U     = 3'b011;
  localparam logic [2:0] SRC_J     = 3'b100;
  localparam logic [2:0] SRC_SHAMT = 3'b101;
  localparam logic [2:0] SRC_Z     = 3'b110;
  localparam logic [2:0] SRC_ILL   = 3'b111;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] val;
  } entry_t;

  // Bit positions refer to inm, i.e. instr[k] = inm[k-7].
  function automatic entry_t extend(input logic [24:0] f, input logic [2:0] s);
    entry_t r;
    r.err = 1'b0;
    r.val = '0;
    case (s)
      SRC_I: r.val = XLEN'($signed(f[24:13]));
      SRC_S: r.val = XLEN'($signed({f[24:18], f[4:0]}));
      SRC_B: r.val = XLEN'($signed({f[24], f[0], f[23:18], f[4:1], 1'b0}));
      SRC_U: r.val = XLEN'($signed({f[24:5], 12'b0}));
      SRC_J: r.val = XLEN'($signed({f[24], f[12:5], f[13], f[23:14], 1'b0}));
      SRC_SHAMT: begin
        if (XLEN == 32) r.val = XLEN'(f[17:13]);
        else            r.val = XLEN'(f[18:13]);
      end
      SRC_Z:   r.val = XLEN'(f[12:8]);
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  entry_t     mem [2];
  entry_t     new_entry;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  logic       ill_push;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready/out_valid come only from registered count, so there
  // is no combinational path from out_ready to in_ready or from inputs to outputs.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign ill_push  = push & (src == SRC_ILL);
  assign new_entry = extend(inm, src);

  assign inmExt  = out_valid ? mem[rd_ptr].val : '0;
  assign fmt_err = out_valid ? mem[rd_ptr].err : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the empty-state outputs are masked above.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (ill_push && !flush && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERRW'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    count <= 2'd2);

  a_empty_zero: assert property (@(posedge clk) disable iff (reset)
    !out_valid |-> (inmExt == '0 && !fmt_err));

  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(inmExt) && $stable(fmt_err)));

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: XLEN=32/ERRW=2 and XLEN=64 instances, directed vectors,
// expected-value queues drained by negedge monitors.
module tb_imm_ext_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] inm;
  logic [2:0]  src;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inm_ext;
  logic        fmt_err;
  logic [1:0]  err_cnt;

  logic        w_flush;
  logic        w_in_valid;
  logic        w_in_ready;
  logic [24:0] w_inm;
  logic [2:0]  w_src;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [63:0] w_inm_ext;
  logic        w_fmt_err;
  logic [7:0]  w_err_cnt;

  imm_ext_pipe #(.XLEN(32), .DEPTH(2), .ERRW(2)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .inm(inm), .src(src),
    .out_valid(out_valid), .out_ready(out_ready),
    .inmExt(inm_ext), .fmt_err(fmt_err), .err_cnt(err_cnt)
  );

  imm_ext_pipe #(.XLEN(64), .DEPTH(2), .ERRW(8)) dut64 (
    .clk(clk), .reset(reset), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .inm(w_inm), .src(w_src),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .inmExt(w_inm_ext), .fmt_err(w_fmt_err), .err_cnt(w_err_cnt)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic [64:0] exp64_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [24:0] f, input logic [2:0] s, input logic [31:0] e);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    inm = f;
    src = s;
    for (int k = 0; k < 40; k++) begin
      if (in_ready) begin
        exp_q.push_back({(s == 3'b111), e});
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 40 cycles expected acceptance");
    end
  endtask

  task automatic send64(input logic [24:0] f, input logic [2:0] s, input logic [63:0] e);
    logic acc;
    acc = 1'b0;
    w_in_valid = 1'b1;
    w_inm = f;
    w_src = s;
    for (int k = 0; k < 40; k++) begin
      if (w_in_ready) begin
        exp64_q.push_back({(s == 3'b111), e});
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    w_in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send64_timeout: got in_ready=0 for 40 cycles expected acceptance");
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 30; k++) begin
      if (exp_q.size() == 0 && exp64_q.size() == 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check({name, "_q32_empty"}, 64'(exp_q.size()), 64'd0);
    check({name, "_q64_empty"}, 64'(exp64_q.size()), 64'd0);
    check({name, "_idle"}, 64'(out_valid), 64'd0);
  endtask

  // ---------------- monitors ----------------
  logic        held_v = 1'b0;
  logic [32:0] held;

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (held_v) check("hold_stable", 64'({fmt_err, inm_ext}), 64'(held));
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h expected no output", {fmt_err, inm_ext});
          end else begin
            e = exp_q.pop_front();
            check("data32", 64'({fmt_err, inm_ext}), 64'(e));
          end
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held = {fmt_err, inm_ext};
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (!reset && w_out_valid && w_out_ready) begin
        if (exp64_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output64: got %0h expected no output", w_inm_ext);
        end else begin
          e = exp64_q.pop_front();
          check("data64_val", w_inm_ext, e[63:0]);
          check("data64_err", 64'(w_fmt_err), 64'(e[64]));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300000");
    $fatal(1, "watchdog");
  end

  // ---------------- directed vectors ----------------
  logic [24:0] t1_inm [6] = '{25'h1000000, 25'h1FFFFFF, 25'b1010101010101010101010101,
                              25'h1FFFFFF, 25'h1000000, 25'h0001500};
  logic [2:0]  t1_src [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
  logic [31:0] t1_exp [6] = '{32'hFFFFF800, 32'hFFFFFFFF, 32'hFFFFFAB4,
                              32'hFFFFF000, 32'hFFF00000, 32'h00000015};

  initial begin
    logic [11:0] v;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inm = '0; src = '0;
    w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1; w_inm = '0; w_src = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_inm_ext", 64'(inm_ext), 64'd0);
    check("rst_fmt_err", 64'(fmt_err), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst64_out_valid", 64'(w_out_valid), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // formats, one request at a time, 1-cycle latency
    for (int i = 0; i < 6; i++) begin
      check("t1_idle", 64'(out_valid), 64'd0);
      send(t1_inm[i], t1_src[i], t1_exp[i]);
      check("t1_latency", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    drain("t1");

    // backpressure: A, B fill the buffer, C waits
    out_ready = 1'b0;
    send({12'h123, 13'h1FFF}, 3'b000, 32'h00000123);
    check("t2_ready_after_a", 64'(in_ready), 64'd1);
    send({12'h456, 13'h0000}, 3'b000, 32'h00000456);
    check("t2_full", 64'(in_ready), 64'd0);
    check("t2_valid", 64'(out_valid), 64'd1);
    fork
      send({12'hABC, 13'h0155}, 3'b000, 32'hFFFFFABC);
      begin
        for (int k = 0; k < 3; k++) begin
          check("t2_held_full", 64'(in_ready), 64'd0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("t2");

    // streaming at count=1: push and pop every cycle
    for (int i = 0; i <= 10; i++) begin
      v = 12'(i * 12'h111);
      send({v, 13'h1ABC}, 3'b000, {{20{v[11]}}, v});
      check("t3_valid", 64'(out_valid), 64'd1);
      check("t3_ready", 64'(in_ready), 64'd1);
    end
    drain("t3");

    // XLEN=64 vectors
    send64(25'h1000000, 3'b000, 64'hFFFFFFFFFFFFF800);
    send64(25'h007E000, 3'b101, 64'h000000000000003F);
    send64(25'h0040000, 3'b101, 64'h0000000000000020);
    send64(25'h0FFFFFF, 3'b011, 64'h000000007FFFF000);
    drain("t6");
    check("t6_err_cnt", 64'(w_err_cnt), 64'd0);

    // flush at count=2 with an illegal request presented
    out_ready = 1'b0;
    send(25'h0002000, 3'b000, 32'h00000001);
    send(25'h0004000, 3'b000, 32'h00000002);
    check("t5_full", 64'(in_ready), 64'd0);
    flush = 1'b1; in_valid = 1'b1; src = 3'b111; inm = 25'h1FFFFFF;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("t5_flush_valid", 64'(out_valid), 64'd0);
    check("t5_flush_ready", 64'(in_ready), 64'd1);
    check("t5_flush_err_cnt", 64'(err_cnt), 64'd0);
    check("t5_flush_ext", 64'(inm_ext), 64'd0);

    // flush at count=1 while an illegal push would be accepted
    send(25'h0006000, 3'b000, 32'h00000003);
    flush = 1'b1; in_valid = 1'b1; src = 3'b111; inm = 25'h1FFFFFF;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("t5_flush2_valid", 64'(out_valid), 64'd0);
    check("t5_flush2_err_cnt", 64'(err_cnt), 64'd0);
    out_ready = 1'b1;
    send(25'h1FFE000, 3'b000, 32'hFFFFFFFF);
    drain("t5");

    // illegal format and err_cnt saturation (ERRW=2)
    for (int n = 1; n <= 5; n++) begin
      send(25'h1FFFFFF, 3'b111, 32'h00000000);
      check("t4_err_cnt", 64'(err_cnt), (n > 3) ? 64'd3 : 64'(n));
    end
    drain("t4");
    check("t4_err_cnt_final", 64'(err_cnt), 64'd3);

    // reset mid-stream
    out_ready = 1'b0;
    send(25'h0002000, 3'b000, 32'h00000001);
    send(25'h1FFFFFF, 3'b111, 32'h00000000);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_ready", 64'(in_ready), 64'd1);
    check("t5_rst_ext", 64'(inm_ext), 64'd0);
    check("t5_rst_fmt_err", 64'(fmt_err), 64'd0);
    check("t5_rst_err_cnt", 64'(err_cnt), 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(25'h1FFFFFF, 3'b001, 32'hFFFFFFFF);
    drain("t5_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Parametrised, pipelined successor to the single-cycle SE sign-extender in the datapath. It takes the instruction immediate field, inm = instr[31:7], and a 3-bit format selector. It covers I/S/B/U/J plus shift-amount and CSR zero-extended formats, sized for XLEN 32 or 64. It sits between decode and execute in the pipelined datapath, behind a 2-entry valid/ready buffer with flush.

Parameters:
XLEN, 32, output width; legal values 32 or 64.
DEPTH, 2, buffer entries; fixed at 2 (skid buffer). Other values are illegal; elaboration fails with $error.
ERRW, 8, width of the saturating illegal-format counter.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high
flush  in  1  synchronous; drops all buffered entries
in_valid  in  1  producer has a request
in_ready  out  1  buffer can accept this cycle
inm  in  25  instr[31:7]
src  in  3  format select
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head
inmExt  out  XLEN  extended immediate of head entry
fmt_err  out  1  head entry had an illegal src
err_cnt  out  ERRW  count of accepted illegal requests, saturating

Behaviour:
- Notation: instr[k] = inm[k-7]; s = inm[24]; SX = sign-extend to XLEN; ZX = zero-extend to XLEN.
- src 000 I: SX(inm[24:13]).
- src 001 S: SX({inm[24:18], inm[4:0]}).
- src 010 B: SX({s, inm[0], inm[23:18], inm[4:1], 1'b0}).
- src 011 U: SX({inm[24:5], 12'b0}); for XLEN=64, bits 63:32 copy s.
- src 100 J: SX({s, inm[12:5], inm[13], inm[23:14], 1'b0}).
- src 101 SHAMT: ZX(inm[17:13]) when XLEN=32; ZX(inm[18:13]) when XLEN=64.
- src 110 Z (CSR uimm): ZX(inm[12:8]).
- src 111: illegal. inmExt = 0, fmt_err = 1. Every other format has fmt_err = 0.
- Extension is computed at push time; each buffer entry stores {inmExt, fmt_err}.
- Handshake:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count < 2). It depends only on registered state, never combinationally on out_ready.
  - out_valid = (count > 0). inmExt and fmt_err always show the head entry.
  - While out_valid & !out_ready, the outputs are held stable.
- Latency: a request pushed at edge N appears at the outputs after edge N (1 cycle). No combinational input-to-output path.
- count transitions:
  - push only: +1.
  - pop only: -1.
  - push and pop: unchanged, head advances.
  - count=2: push impossible; pop takes it to 1.
  - count=0: no pop.
- Ordering: strict FIFO. The read/write pointers are 1 bit each and wrap modulo 2.
- err_cnt increments by 1 on each push with src=111. It saturates at 2^ERRW-1; further illegal pushes leave it unchanged.
- flush: at the next edge, count=0 and pointers=0, so out_valid=0 and in_ready=1.
  - A push or pop in the same cycle as flush is discarded.
  - err_cnt is not cleared by flush, and an illegal push discarded by flush does not count.
- reset (priority over flush):
  - count=0, pointers=0, err_cnt=0, out_valid=0, in_ready=1, inmExt=0, fmt_err=0.
  - Entry contents need no reset, but the outputs must read 0 while empty.
  - A reset mid-stream discards all entries.

Test Plan:
1. XLEN=32, out_ready=1, with one 1-cycle request each:
   - I, inm=25'h1000000 -> 0xFFFFF800.
   - S, all ones -> 0xFFFFFFFF.
   - B, inm=25'b1010101010101010101010101 -> 0xFFFFFAB4.
   - U, all ones -> 0xFFFFF000.
   - J, inm=25'h1000000 -> 0xFFF00000.
   - Z, inm[12:8]=5'b10101 -> 0x00000015.
   - Each result has out_valid high exactly one cycle after the push.
2. Backpressure:
   - out_ready=0; push A, B, C on consecutive cycles -> in_ready=0 after the 2nd push and C is held.
   - Then out_ready=1 -> A, B, C emerge in order with no loss or duplication.
   - Outputs stay stable while stalled.
3. Simultaneous push/pop at count=1 for 10 cycles -> count stays 1 and the data stream matches the input order with 1-cycle latency.
4. Illegal src=111 -> inmExt=0, fmt_err=1, err_cnt+1. With ERRW=2, 5 illegal pushes -> err_cnt=3 (saturated).
5. flush at count=2 with an illegal push in the same cycle -> next cycle out_valid=0, in_ready=1, err_cnt unchanged. reset asserted mid-stream -> all outputs 0, err_cnt=0.
6. XLEN=64:
   - I, inm=25'h1000000 -> 0xFFFFFFFFFFFFF800.
   - SHAMT, inm[18:13]=6'b111111 -> 0x000000000000003F.
   - U, inm=25'h0FFFFFF -> 0x000000007FFFF000.
